// File: rtl/chess_pkg.sv
// Shared types and defaults for the player move controller.
package chess_pkg;

  localparam int BOARD_SQ_DEFAULT = 64;
  localparam int PIECE_W_DEFAULT  = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEL_SRC,
    GEN,
    SEL_DST,
    COMMIT
  } move_state_e;

  typedef enum logic [1:0] {
    ERR_NOT_OWN  = 2'd0,
    ERR_NO_MOVES = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

endpackage

// File: rtl/player_move_ctrl_turn_timer.sv
// Idle-cycle counter for the turn forfeit feature (only built when MOVE_TIMEOUT_EN is defined).
// expired is asserted in the cycle where the count sits at TIMEOUT_CYC-1 with no clear pending.
module turn_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance while enabled and hold when halted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/player_move_ctrl.sv
// Two-step player move controller: source select -> legal-move fetch ->
// destination select -> board commit over valid/ready.
// Optional turn forfeit on inactivity: define MOVE_TIMEOUT_EN.
module player_move_ctrl
  import chess_pkg::*;
#(
  parameter int BOARD_SQ    = BOARD_SQ_DEFAULT,
  parameter int POS_W       = $clog2(BOARD_SQ),
  parameter int PIECE_W     = PIECE_W_DEFAULT,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                turn_start,
  input  logic [BOARD_SQ-1:0] own_mask,
  input  logic [POS_W-1:0]    selected_position,
  input  logic [PIECE_W-1:0]  piece_code,
  input  logic                confirm_move,
  input  logic                cancel,
  output logic                gen_req,
  output logic [POS_W-1:0]    gen_src,
  input  logic                gen_done,
  input  logic [BOARD_SQ-1:0] valid_moves,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [POS_W-1:0]    upd_from,
  output logic [POS_W-1:0]    upd_to,
  output logic [PIECE_W-1:0]  upd_piece,
  output logic                error_message,
  output logic [1:0]          error_code,
  output logic                turn_done,
  output logic                busy
);

  // Parameter sanity checks, resolved at elaboration.
  if (BOARD_SQ < 2) begin : g_bad_board_sq
    $error("player_move_ctrl: BOARD_SQ must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("player_move_ctrl: TIMEOUT_CYC must be at least 1");
  end

  move_state_e          state_q, state_d;
  logic [POS_W-1:0]     src_q, src_d;
  logic [PIECE_W-1:0]   piece_q, piece_d;
  logic [BOARD_SQ-1:0]  mask_q, mask_d;
  logic [POS_W-1:0]     to_q, to_d;
  logic                 gen_req_q, gen_req_d;
  logic                 upd_valid_q, upd_valid_d;
  logic                 err_q, err_d;
  err_e                 code_q, code_d;
  logic                 turn_done_q, turn_done_d;
  logic                 busy_q, busy_d;

  // Square lookups; squares past the end of the board never match.
  logic pos_in_range, own_hit, dst_hit, is_src;
  assign pos_in_range = int'(selected_position) < BOARD_SQ;
  assign own_hit      = pos_in_range && own_mask[selected_position];
  assign dst_hit      = pos_in_range && mask_q[selected_position];
  assign is_src       = (selected_position == src_q);

  logic timeout;

`ifdef MOVE_TIMEOUT_EN
  logic timer_en, timer_clr;

  // Count only while the player owes an input; entry to SEL_SRC restarts it.
  assign timer_en  = (state_q == SEL_SRC) || (state_q == GEN) || (state_q == SEL_DST);
  assign timer_clr = confirm_move || cancel
                   || ((state_q == IDLE) && turn_start)
                   || ((state_q == GEN) && gen_done && (valid_moves == '0));

  turn_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_turn_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    piece_d     = piece_q;
    mask_d      = mask_q;
    to_d        = to_q;
    upd_valid_d = upd_valid_q;
    code_d      = code_q;
    gen_req_d   = 1'b0;
    err_d       = 1'b0;
    turn_done_d = 1'b0;

    if (timeout) begin
      // Forfeit: end the turn with no board update.
      state_d     = IDLE;
      err_d       = 1'b1;
      code_d      = ERR_TIMEOUT;
      turn_done_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (turn_start) state_d = SEL_SRC;
        end
        SEL_SRC: begin
          if (confirm_move) begin
            if (own_hit) begin
              src_d     = selected_position;
              piece_d   = piece_code;
              gen_req_d = 1'b1;
              state_d   = GEN;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_NOT_OWN;
            end
          end
        end
        GEN: begin
          if (gen_done) begin
            if (valid_moves == '0) begin
              err_d   = 1'b1;
              code_d  = ERR_NO_MOVES;
              state_d = SEL_SRC;
            end else begin
              mask_d  = valid_moves;
              state_d = SEL_DST;
            end
          end
        end
        SEL_DST: begin
          if (cancel) begin
            state_d = SEL_SRC;
          end else if (confirm_move) begin
            if (is_src) begin
              state_d = SEL_SRC;
            end else if (dst_hit) begin
              to_d        = selected_position;
              upd_valid_d = 1'b1;
              state_d     = COMMIT;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_ILLEGAL;
            end
          end
        end
        COMMIT: begin
          if (upd_valid_q && upd_ready) begin
            upd_valid_d = 1'b0;
            turn_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      piece_q     <= '0;
      // NOTE: the latched legal-move mask is reset too, so no stale legality survives a restart.
      mask_q      <= '0;
      to_q        <= '0;
      gen_req_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NOT_OWN;
      turn_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      piece_q     <= piece_d;
      mask_q      <= mask_d;
      to_q        <= to_d;
      gen_req_q   <= gen_req_d;
      upd_valid_q <= upd_valid_d;
      err_q       <= err_d;
      code_q      <= code_d;
      turn_done_q <= turn_done_d;
      busy_q      <= busy_d;
    end
  end

  assign gen_req       = gen_req_q;
  assign gen_src       = src_q;
  assign upd_valid     = upd_valid_q;
  assign upd_from      = src_q;
  assign upd_to        = to_q;
  assign upd_piece     = piece_q;
  assign error_message = err_q;
  assign error_code    = code_q;
  assign turn_done     = turn_done_q;
  assign busy          = busy_q;

endmodule
